// File: rtl/ofifo_col.sv
// Per-column output FIFOs between the systolic array and the psum SRAM write path.
// Columns fill independently; a read pops one entry from every column at once (one row).
module ofifo_col #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int DEPTH   = 64,
    parameter int PTR_W   = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col-1:0]         wr,
    input  logic [col*psum_bw-1:0] i_data,
    input  logic                   rd,
    output logic [col*psum_bw-1:0] o_data,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);

    logic [col-1:0] col_nonempty;
    logic [col-1:0] col_full;
    logic [col-1:0] col_drop;
    logic           rd_ok;
    logic           overflow_reg;
    logic           underflow_reg;

    // Flags depend only on the column counts, never on this cycle's wr/rd.
    assign o_valid   = &col_nonempty;
    assign o_full    = |col_full;
    assign o_ready   = ~o_full;
    assign rd_ok     = rd & o_valid;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

    generate
        for (genvar gi = 0; gi < col; gi++) begin : g_col
            logic [psum_bw-1:0] mem [DEPTH];
            logic [PTR_W-1:0]   wptr_reg;
            logic [PTR_W-1:0]   rptr_reg;
            logic [CNT_W-1:0]   cnt_reg;
            logic [CNT_W-1:0]   cnt_next;
            logic               wr_ok;

            assign col_nonempty[gi] = (cnt_reg != '0);
            assign col_full[gi]     = (cnt_reg == CNT_MAX);
            // A full column still accepts a write when a row pops in the same cycle.
            assign wr_ok            = wr[gi] & (~col_full[gi] | rd_ok);
            assign col_drop[gi]     = wr[gi] & col_full[gi] & ~rd_ok;

            always_comb begin
                cnt_next = cnt_reg;
                if (wr_ok && !rd_ok) begin
                    cnt_next = cnt_reg + CNT_ONE;
                end else if (!wr_ok && rd_ok) begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    wptr_reg <= '0;
                    rptr_reg <= '0;
                    cnt_reg  <= '0;
                end else begin
                    if (wr_ok) begin
                        wptr_reg <= wptr_reg + PTR_ONE;
                    end
                    if (rd_ok) begin
                        rptr_reg <= rptr_reg + PTR_ONE;
                    end
                    cnt_reg <= cnt_next;
                end
            end

            // Storage is never cleared; a write coinciding with reset is simply not stored.
            always_ff @(posedge clk) begin
                if (reset && wr_ok) begin
                    mem[wptr_reg] <= i_data[gi*psum_bw +: psum_bw];
                end
            end

            assign o_data[gi*psum_bw +: psum_bw] = mem[rptr_reg];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (|col_drop) begin
                overflow_reg <= 1'b1;
            end
            if (rd && !o_valid) begin
                underflow_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ofifo_col.sv
// Directed and randomized bench for ofifo_col with DEPTH=4, checked against a
// row-list reference model (per-column ordered lists with head at index 0).
module tb_ofifo_col;

    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int DEPTH = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [COL-1:0]      wr;
    logic [COL*BW-1:0]   i_data;
    logic                rd;
    logic [COL*BW-1:0]   o_data;
    logic                o_valid;
    logic                o_full;
    logic                o_ready;
    logic                overflow;
    logic                underflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [BW-1:0] mq [COL][DEPTH+1];
    int            msz [COL];
    logic          m_ovf;
    logic          m_unf;

    ofifo_col #(.col(COL), .psum_bw(BW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr),
        .i_data   (i_data),
        .rd       (rd),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .o_full   (o_full),
        .o_ready  (o_ready),
        .overflow (overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    function automatic logic exp_valid();
        logic v = 1'b1;
        for (int c = 0; c < COL; c++) if (msz[c] == 0) v = 1'b0;
        return v;
    endfunction

    function automatic logic exp_full();
        logic f = 1'b0;
        for (int c = 0; c < COL; c++) if (msz[c] == DEPTH) f = 1'b1;
        return f;
    endfunction

    function automatic logic [COL*BW-1:0] exp_data();
        logic [COL*BW-1:0] d = '0;
        for (int c = 0; c < COL; c++) d[c*BW +: BW] = mq[c][0];
        return d;
    endfunction

    function automatic logic [COL*BW-1:0] rowval(input logic [BW-1:0] v);
        return {COL{v}};
    endfunction

    // Reference behaviour at a clock edge: pushes append, a row pop removes every head.
    task automatic model_step();
        logic valid;
        logic rd_ok;
        if (!reset) begin
            for (int c = 0; c < COL; c++) msz[c] = 0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            valid = exp_valid();
            rd_ok = rd && valid;
            if (rd && !valid) m_unf = 1'b1;
            for (int c = 0; c < COL; c++) begin
                if (wr[c]) begin
                    if (msz[c] < DEPTH || rd_ok) begin
                        mq[c][msz[c]] = i_data[c*BW +: BW];
                        msz[c]++;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
            if (rd_ok) begin
                for (int c = 0; c < COL; c++) begin
                    for (int i = 0; i < msz[c] - 1; i++) mq[c][i] = mq[c][i+1];
                    msz[c]--;
                end
            end
        end
    endtask

    task automatic tick();
        logic [COL-1:0] wr_s  = wr;
        logic           rd_s  = rd;
        logic           rst_s = reset;
        @(posedge clk);
        model_step();
        @(negedge clk);
        $display("t=%0t rst=%b wr=%h rd=%b -> valid=%b full=%b ready=%b ovf=%b unf=%b data=%h",
                 $time, rst_s, wr_s, rd_s, o_valid, o_full, o_ready, overflow, underflow, o_data);
    endtask

    task automatic test_reset();
        reset = 1'b0; wr = '0; rd = 1'b0; i_data = '0;
        tick();
        tick();
        reset = 1'b1;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        n_checks++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", o_full); end
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_unf got=%b exp=0", underflow); end
    endtask

    task automatic test_skewed_fill();
        logic [COL*BW-1:0] exp;
        for (int k = 0; k < COL; k++) begin
            wr = COL'(1) << k;
            i_data = {$urandom, $urandom, $urandom, $urandom};
            i_data[k*BW +: BW] = 16'h0100 + 16'(k);
            exp[k*BW +: BW] = 16'h0100 + 16'(k);
            tick();
            n_checks++;
            if (o_valid !== (k == COL - 1)) begin
                n_fail++; $display("FAIL skew_valid k=%0d got=%b exp=%b", k, o_valid, (k == COL - 1));
            end
        end
        wr = '0;
        n_checks++; if (o_data !== exp) begin n_fail++; $display("FAIL skew_data got=%h exp=%h", o_data, exp); end
        rd = 1'b1;
        tick();
        rd = 1'b0;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL skew_pop_valid got=%b exp=0", o_valid); end
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL skew_unf got=%b exp=0", underflow); end
    endtask

    task automatic test_overflow();
        for (int r = 1; r <= DEPTH; r++) begin
            wr = '1; i_data = rowval(16'(r));
            tick();
        end
        n_checks++; if (o_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full_before got=%b exp=1", o_full); end
        i_data = rowval(16'd5);
        tick();
        wr = '0;
        n_checks++; if (o_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full got=%b exp=1", o_full); end
        n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_ready got=%b exp=0", o_ready); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        for (int r = 1; r <= DEPTH; r++) begin
            n_checks++;
            if (o_data !== rowval(16'(r))) begin
                n_fail++; $display("FAIL ovf_row%0d got=%h exp=%h", r, o_data, rowval(16'(r)));
            end
            rd = 1'b1;
            tick();
            rd = 1'b0;
        end
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained got=%b exp=0", o_valid); end
    endtask

    task automatic test_full_rdwr();
        int vals [4] = '{2, 3, 4, 9};
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int r = 1; r <= DEPTH; r++) begin
            wr = '1; i_data = rowval(16'(r));
            tick();
        end
        n_checks++; if (o_data !== rowval(16'd1)) begin n_fail++; $display("FAIL frw_head got=%h exp=%h", o_data, rowval(16'd1)); end
        rd = 1'b1; wr = '1; i_data = rowval(16'd9);
        tick();
        rd = 1'b0; wr = '0;
        n_checks++; if (o_full !== 1'b1) begin n_fail++; $display("FAIL frw_full got=%b exp=1", o_full); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL frw_ovf got=%b exp=0", overflow); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (o_data !== rowval(16'(vals[i]))) begin
                n_fail++; $display("FAIL frw_row%0d got=%h exp=%h", i, o_data, rowval(16'(vals[i])));
            end
            rd = 1'b1;
            tick();
            rd = 1'b0;
        end
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL frw_drained got=%b exp=0", o_valid); end
    endtask

    task automatic test_underflow();
        rd = 1'b1;
        tick();
        rd = 1'b0;
        n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_flag got=%b exp=1", underflow); end
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL unf_valid got=%b exp=0", o_valid); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL unf_ovf got=%b exp=0", overflow); end
        wr = '1; i_data = rowval(16'h0055);
        tick();
        wr = '0;
        n_checks++; if (o_data !== rowval(16'h0055)) begin n_fail++; $display("FAIL unf_data got=%h exp=%h", o_data, rowval(16'h0055)); end
        rd = 1'b1;
        tick();
        rd = 1'b0;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL unf_single_row got=%b exp=0", o_valid); end
        n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_sticky got=%b exp=1", underflow); end
    endtask

    task automatic test_midstream_reset();
        for (int r = 1; r <= 3; r++) begin
            wr = '1; i_data = rowval(16'h0030 + 16'(r));
            tick();
        end
        wr = '0;
        n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL mrst_loaded got=%b exp=1", o_valid); end
        reset = 1'b0; wr = '1; rd = 1'b1; i_data = rowval(16'h00AA);
        tick();
        reset = 1'b1; wr = '0; rd = 1'b0;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_valid got=%b exp=0", o_valid); end
        n_checks++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL mrst_full got=%b exp=0", o_full); end
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_ready got=%b exp=1", o_ready); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mrst_ovf got=%b exp=0", overflow); end
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL mrst_unf got=%b exp=0", underflow); end
        wr = '1; i_data = rowval(16'h0077);
        tick();
        wr = '0;
        n_checks++; if (o_data !== rowval(16'h0077)) begin n_fail++; $display("FAIL mrst_new_head got=%h exp=%h", o_data, rowval(16'h0077)); end
        rd = 1'b1;
        tick();
        rd = 1'b0;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_one_row got=%b exp=0", o_valid); end
    endtask

    task automatic test_random();
        int pw;
        int pr;
        for (int n = 0; n < 400; n++) begin
            pw = ((n / 40) % 2 == 0) ? 70 : 30;
            pr = ((n / 40) % 2 == 0) ? 30 : 75;
            reset = ($urandom_range(0, 79) != 0);
            for (int c = 0; c < COL; c++) wr[c] = ($urandom_range(0, 99) < pw);
            rd = ($urandom_range(0, 99) < pr);
            i_data = {$urandom, $urandom, $urandom, $urandom};
            tick();
            n_checks++; if (o_valid !== exp_valid()) begin n_fail++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, o_valid, exp_valid()); end
            n_checks++; if (o_full !== exp_full()) begin n_fail++; $display("FAIL rnd_full n=%0d got=%b exp=%b", n, o_full, exp_full()); end
            n_checks++; if (o_ready !== !exp_full()) begin n_fail++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, o_ready, !exp_full()); end
            n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf n=%0d got=%b exp=%b", n, overflow, m_ovf); end
            n_checks++; if (underflow !== m_unf) begin n_fail++; $display("FAIL rnd_unf n=%0d got=%b exp=%b", n, underflow, m_unf); end
            if (exp_valid()) begin
                n_checks++;
                if (o_data !== exp_data()) begin
                    n_fail++; $display("FAIL rnd_data n=%0d got=%h exp=%h", n, o_data, exp_data());
                end
            end
        end
        reset = 1'b1; wr = '0; rd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_skewed_fill();
        test_overflow();
        test_full_rdwr();
        test_underflow();
        test_midstream_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ofifo_col.md
Name: ofifo_col

Overview:
- Output FIFO between the systolic array columns inside the corelet and the psum SRAM write path.
- Each of `col` columns has its own FIFO. Each FIFO captures that column's psum whenever the column's valid strobe pulses. Columns drain skewed in time.
- A read pops one row, meaning one entry from every column at once. A read is only legal once every column holds data.
- `o_valid` drives the core's `ofifo_valid`. `o_data` feeds the psum SRAM D port.

Parameters:
- col, 8, number of array columns (independent FIFOs).
- psum_bw, 16, width of one psum entry.
- DEPTH, 64, entries per column FIFO. Must be a power of two, at least 2.
- PTR_W, $clog2(DEPTH), pointer width. Derived; do not override.

Ports:
- clk  input  1  clock. All logic triggers on the rising edge.
- reset  input  1  synchronous, active-low reset. `reset==0` at a rising clk edge resets the block.
- wr  input  col  per-column write strobe. Bit c pushes `i_data` slice c.
- i_data  input  col*psum_bw  column psums. Slice c is `[psum_bw*(c+1)-1 : psum_bw*c]`.
- rd  input  1  pop one entry from every column.
- o_data  output  col*psum_bw  head entry of every column, same slice mapping as `i_data`.
- o_valid  output  1  every column non-empty.
- o_full  output  1  at least one column full.
- o_ready  output  1  no column full (equals `~o_full`).
- overflow  output  1  sticky error: a write was dropped.
- underflow  output  1  sticky error: a read was ignored.

Behaviour:
- Storage and counters per column c:
  - mem_c[DEPTH] of psum_bw bits.
  - wptr_c and rptr_c, each PTR_W bits, wrapping modulo DEPTH.
  - cnt_c, PTR_W+1 bits, range 0..DEPTH.
- Reset (`reset==0` at a clk edge):
  - All pointers, counts, `overflow` and `underflow` go to 0.
  - Memory contents are not cleared.
  - Resulting outputs: `o_valid=0`, `o_full=0`, `o_ready=1`, `o_data` = don't-care, the flags 0.
  - Reset has priority over `wr` and `rd` in the same cycle, so a reset mid-stream discards all data.
- Flag derivation: `o_valid`, `o_full` and `o_ready` are combinational from the cnt_c values only, never directly from `wr` or `rd`.
- Read acceptance: `rd_ok = rd & o_valid`.
  - When `rd_ok`, every rptr_c increments.
  - `rd & ~o_valid` pops nothing and sets `underflow` to 1 on the next edge.
- Write acceptance for column c: `wr_ok_c = wr[c] & (cnt_c < DEPTH | rd_ok)`.
  - A full column accepts a write in the same cycle as an accepted read; the freed slot is reused.
  - When `wr_ok_c`, mem_c[wptr_c] <= slice c and wptr_c increments.
  - `wr[c]` while the column is full and `~rd_ok` drops the data, leaves the pointers unchanged, and sets `overflow` to 1 on the next edge.
- Count update: cnt_c next = cnt_c + wr_ok_c − rd_ok. Simultaneous push and pop leaves the count unchanged.
- Empty column with `wr[c]` and `rd` together: `o_valid=0` so the read is rejected; the write still lands.
- `o_data` is first-word fall-through:
  - `o_data` slice c = mem_c[rptr_c], combinational from the registered read pointer.
  - Latency: data written on edge N is visible on `o_data` after edge N, provided all columns are non-empty.
  - Data read on edge N is replaced by the next entry after edge N.
- Pointer wrap at DEPTH−1 → 0 is silent. The FIFO is ordered per column, so entry k of every column forms row k.
- `overflow` and `underflow` clear only on reset.

Test Plan (bench overrides DEPTH=4, col=8, psum_bw=16):
- Reset low for 2 cycles, then high → `o_valid=0`, `o_full=0`, `o_ready=1`, `overflow=0`, `underflow=0`.
- Skewed fill: on cycle k (k=0..7) pulse `wr[k]` with slice k = 16'h0100+k → `o_valid` stays 0 until the edge after cycle 7, then 1. `o_data` = {16'h0107,…,16'h0100}. Assert `rd` one cycle → `o_valid` returns to 0.
- Fill all columns with 4 rows (values 1..4), then pulse `wr=8'hFF` with data 5 → `o_full=1`, `o_ready=0`, `overflow=1`. Four reads return rows 1,2,3,4 in order; data 5 never appears.
- Full plus simultaneous `rd` and `wr=8'hFF` with data 9 → read returns 1, count stays 4, `overflow` stays 0. Subsequent reads return 2,3,4,9, which exercises pointer wrap.
- `rd=1` while empty → no state change except `underflow=1`, which persists until reset.
- Mid-stream reset: 3 rows loaded, `reset=0` with `wr=8'hFF` and `rd=1` in the same cycle → after the edge, all counts are 0, `o_valid=0`, the flags are 0, and the written data is discarded.
